// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio_pkg
//  Description : Shared constants for the UART MMIO controller. These are the
//                register offsets inside the I/O window and the bit positions
//                of the status word.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_mmio_pkg;

    // Register offsets relative to IO_BASE (low address byte)
    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYC    = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CRST   = 8'h18;
    localparam logic [7:0] OFF_SCLR   = 8'h1C;

    // Status word bit positions
    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_OVF   = 3;

    // Assemble the status word; every bit not named here reads 0
    function automatic logic [31:0] status_word(input logic tx_ready,
                                                input logic rx_valid,
                                                input logic tx_ovf,
                                                input logic rx_ovf);
        logic [31:0] w;
        w              = '0;
        w[ST_TX_READY] = tx_ready;
        w[ST_RX_VALID] = rx_valid;
        w[ST_TX_OVF]   = tx_ovf;
        w[ST_RX_OVF]   = rx_ovf;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mmio_ctrl_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_byte_fifo
//  Description : Generic synchronous circular FIFO. Pushes into a full FIFO
//                and pops from an empty FIFO are ignored. rdata_o shows the
//                oldest entry whenever the FIFO is not empty. full_next_o is
//                the full flag after the current cycle's push/pop, so a
//                registered ready in the parent matches the new occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       full_next_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    assign full_next_o = (count_d == CW'(DEPTH));

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio_ctrl
//  Description : Memory-mapped I/O controller between the CPU memory stage
//                and the UART. It decodes the I/O window and provides a
//                one-deep TX holding register, a receive buffer, sticky
//                overflow flags, and the cycle and retired-instruction
//                counters.
//                Build option UART_RX_FIFO_EN: when defined, the receive
//                buffer is an RX_DEPTH-entry FIFO. When undefined, it is a
//                single-byte holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int          RX_DEPTH = 8,
    parameter logic [31:0] IO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    input  logic        inst_retired,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    // Reject unusable FIFO depths at elaboration
    if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("uart_mmio_ctrl: RX_DEPTH must be a power of two and at least 2");
    end

    logic [31:0] io_rdata_q;
    logic [31:0] rd_data_d;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        tx_ovf_q;
    logic        rx_ovf_q;
    logic        rx_ready_q;
    logic [31:0] cyc_q;
    logic [31:0] inst_q;

    logic        w_in_win;
    logic [7:0]  w_off;
    logic        w_rd;
    logic        w_wr;
    logic        w_tx_wr;
    logic        w_crst;
    logic        w_sclr;
    logic        w_push;
    logic        w_pop;
    logic        w_rx_nonempty;
    logic        w_rx_full;
    logic        w_rx_full_next;
    logic [7:0]  w_rx_head;
    logic        w_unused_wdata;

    // Only the low byte of store data is meaningful for the TX register
    assign w_unused_wdata = ^io_wdata[31:8];

    // Address decode: accesses outside the window have no effect at all
    assign w_in_win = (io_addr[31:8] == IO_BASE[31:8]);
    assign w_off    = io_addr[7:0];
    assign w_rd     = io_re & w_in_win;
    assign w_wr     = io_we & w_in_win;
    assign w_tx_wr  = w_wr & (w_off == OFF_TX);
    assign w_crst   = w_wr & (w_off == OFF_CRST);
    assign w_sclr   = w_wr & (w_off == OFF_SCLR);

    // The buffer accepts a byte only while ready is advertised. A pop
    // happens only when the buffer is non-empty, so a read on an empty
    // buffer returns 0 and pops nothing.
    assign w_push = uart_rx_valid & rx_ready_q;
    assign w_pop  = w_rd & (w_off == OFF_RX) & w_rx_nonempty;

`ifdef UART_RX_FIFO_EN
    logic [$clog2(RX_DEPTH):0] w_rx_count;

    rx_byte_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .wdata_i     (uart_rx_data),
        .rdata_o     (w_rx_head),
        .full_o      (w_rx_full),
        .full_next_o (w_rx_full_next),
        .count_o     (w_rx_count)
    );

    assign w_rx_nonempty = (w_rx_count != '0);
`else
    logic       rx_full_q;
    logic [7:0] rx_byte_q;

    assign w_rx_nonempty  = rx_full_q;
    assign w_rx_full      = rx_full_q;
    assign w_rx_head      = rx_byte_q;
    assign w_rx_full_next = (rx_full_q & ~w_pop) | w_push;

    // Single-byte receive holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full_q <= 1'b0;
            rx_byte_q <= 8'h00;
        end else begin
            if (w_push) begin
                rx_byte_q <= uart_rx_data;
            end
            rx_full_q <= w_rx_full_next;
        end
    end
`endif

    // Load data mux; status and counters reflect the state before any
    // write in the same cycle
    always_comb begin
        rd_data_d = '0;
        case (w_off)
            OFF_STATUS: rd_data_d = status_word(~tx_valid_q, w_rx_nonempty, tx_ovf_q, rx_ovf_q);
            OFF_RX:     rd_data_d = {24'h0, (w_rx_nonempty ? w_rx_head : 8'h00)};
            OFF_CYC:    rd_data_d = cyc_q;
            OFF_INST:   rd_data_d = inst_q;
            default:    rd_data_d = '0;
        endcase
    end

    // Registered load data, held when there is no qualified read
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata_q <= '0;
        end else if (w_rd) begin
            io_rdata_q <= rd_data_d;
        end
    end

    // TX holding register. A write while occupied is dropped, even if the
    // handshake completes in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else if (tx_valid_q) begin
            if (uart_tx_ready) begin
                tx_valid_q <= 1'b0;
            end
        end else if (w_tx_wr) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= io_wdata[7:0];
        end
    end

    // Sticky overflow flags; a new overflow wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            if (w_sclr) begin
                tx_ovf_q <= 1'b0;
                rx_ovf_q <= 1'b0;
            end
            if (w_tx_wr && tx_valid_q) begin
                tx_ovf_q <= 1'b1;
            end
            if (uart_rx_valid && w_rx_full) begin
                rx_ovf_q <= 1'b1;
            end
        end
    end

    // RX ready follows the post-update occupancy one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_q <= 1'b0;
        end else begin
            rx_ready_q <= ~w_rx_full_next;
        end
    end

    // Free-running counters; a counter-reset write wins over an increment
    always_ff @(posedge clk) begin
        if (rst || w_crst) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            cyc_q  <= cyc_q + 32'd1;
            inst_q <= inst_q + {31'd0, inst_retired};
        end
    end

    assign io_rdata      = io_rdata_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_valid = tx_valid_q;
    assign uart_rx_ready = rx_ready_q;

endmodule
`default_nettype wire
